// File: rtl/i_cache_dm.sv
// Direct-mapped instruction cache: combinational hit path, tag/valid storage,
// and a multi-beat line refill engine on a req/ack memory port.
module i_cache_dm #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned WORDS_PER_LINE = 4,
  parameter int unsigned NUM_LINES      = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h0040_0000)
) (
  input  logic                                 clk,
  input  logic                                 i_rst,
  input  logic [ADDR_WIDTH-1:0]                pc_in,
  input  logic                                 rd_en,
  input  logic                                 abort,
  input  logic                                 invalidate,
  output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] dout,
  output logic                                 dout_valid,
  output logic                                 fetch_err,
  output logic                                 mem_req,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  input  logic                                 mem_ack,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
);

  localparam int unsigned LINE_BITS  = DATA_WIDTH * WORDS_PER_LINE;
  localparam int unsigned OFF_BITS   = $clog2(WORDS_PER_LINE * DATA_WIDTH / 8);
  localparam int unsigned INDEX_BITS = $clog2(NUM_LINES);
  localparam int unsigned LOFF_BITS  = ADDR_WIDTH - OFF_BITS;
  localparam int unsigned TAG_BITS   = LOFF_BITS - INDEX_BITS;
  localparam int unsigned BEAT_BITS  = $clog2(WORDS_PER_LINE);

  typedef enum logic [0:0] {IDLE, REFILL} state_t;

  state_t                  state_q, state_d;
  logic [LINE_BITS-1:0]    data_q [NUM_LINES];
  logic [TAG_BITS-1:0]     tag_arr_q [NUM_LINES];
  logic [NUM_LINES-1:0]    valid_q;
  logic [DATA_WIDTH-1:0]   fill_q [WORDS_PER_LINE];
  logic [INDEX_BITS-1:0]   fill_idx_q;
  logic [TAG_BITS-1:0]     fill_tag_q;
  logic [BEAT_BITS-1:0]    beat_q;
  logic                    discard_q;

  logic [ADDR_WIDTH-1:0]   off;
  logic [LOFF_BITS-1:0]    line_off;
  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_BITS-1:0]     tag;
  logic                    in_range;
  logic                    resident;
  logic                    hit;
  logic                    launch;
  logic                    last_ack;
  logic                    commit;
  logic [LINE_BITS-1:0]    fill_line;

  // Address decode relative to the cacheable base
  assign off      = pc_in - BASE_ADDR;
  assign line_off = LOFF_BITS'(off >> OFF_BITS);
  assign idx      = line_off[INDEX_BITS-1:0];
  assign tag      = line_off[LOFF_BITS-1:INDEX_BITS];
  assign in_range = (pc_in >= BASE_ADDR);
  assign resident = valid_q[idx] && (tag_arr_q[idx] == tag);

  assign hit      = (state_q == IDLE) && rd_en && in_range && resident && !abort;
  assign launch   = (state_q == IDLE) && rd_en && in_range && !resident && !abort && !invalidate;
  assign last_ack = (state_q == REFILL) && mem_ack && (beat_q == BEAT_BITS'(WORDS_PER_LINE - 1));
  // A cancel arriving with the final beat still drops the line
  assign commit   = last_ack && !discard_q && !abort && !invalidate;

  // Final beat bypasses the fill buffer so the line commits on the same edge
  always_comb begin
    fill_line = '0;
    for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
      fill_line[w*DATA_WIDTH +: DATA_WIDTH] = (beat_q == BEAT_BITS'(w)) ? mem_rdata : fill_q[w];
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    fetch_err  = rd_en && !in_range;
    case (state_q)
      IDLE: begin
        dout_valid = hit;
        if (hit)    dout    = data_q[idx];
        if (launch) state_d = REFILL;
      end
      REFILL: begin
        mem_req = 1'b1;
        if (last_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state that must come out of reset clean
  always_ff @(posedge clk) begin
    if (i_rst) begin
      valid_q   <= '0;
      beat_q    <= '0;
      discard_q <= 1'b0;
      mem_addr  <= '0;
    end else begin
      if (launch) begin
        mem_addr  <= {pc_in[ADDR_WIDTH-1:OFF_BITS], OFF_BITS'(0)};
        beat_q    <= '0;
        discard_q <= 1'b0;
      end
      if (state_q == REFILL) begin
        if (mem_ack)              beat_q    <= beat_q + BEAT_BITS'(1);
        if (abort || invalidate)  discard_q <= 1'b1;
        if (last_ack)             discard_q <= 1'b0;
      end
      if (invalidate)  valid_q             <= '0;
      else if (commit) valid_q[fill_idx_q] <= 1'b1;
    end
  end

  // Line storage and refill datapath; contents are don't-care until validated
  always_ff @(posedge clk) begin
    if (launch) begin
      fill_idx_q <= idx;
      fill_tag_q <= tag;
    end
    if ((state_q == REFILL) && mem_ack) fill_q[beat_q] <= mem_rdata;
    if (commit) begin
      data_q[fill_idx_q]    <= fill_line;
      tag_arr_q[fill_idx_q] <= fill_tag_q;
    end
  end

endmodule

// File: doc/i_cache_dm.md
# i_cache_dm

Parametrised direct-mapped instruction cache with tag/valid storage and a miss-refill engine. Sits between the fetch stage and program memory, replacing the flat line-indexed ROM. Hits return a full line combinationally; misses run a multi-beat refill on a req/ack memory port. Supports fetch abort, whole-cache invalidate and out-of-range detection.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, memory beat / instruction word width
- WORDS_PER_LINE, 4, words per line (power of 2, ≥2); LINE_BITS = DATA_WIDTH*WORDS_PER_LINE
- NUM_LINES, 64, lines (power of 2)
- BASE_ADDR, 32'h0040_0000, lowest cacheable byte address
- clk  in  1  clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- pc_in  in  ADDR_WIDTH  fetch byte address
- rd_en  in  1  fetch request
- abort  in  1  cancel current fetch / pending refill
- invalidate  in  1  clear all valid bits
- dout  out  LINE_BITS  line data, word 0 in bits [DATA_WIDTH-1:0]
- dout_valid  out  1  dout holds the line for pc_in this cycle
- fetch_err  out  1  rd_en with pc_in outside cacheable range
- mem_req  out  1  refill request, held high until last beat acked
- mem_addr  out  ADDR_WIDTH  line-aligned absolute refill address, stable while mem_req
- mem_ack  in  1  one beat accepted, mem_rdata valid
- mem_rdata  in  DATA_WIDTH  refill beat data

## Operation
- Address split on off = pc_in − BASE_ADDR: OFF_BITS = log2(WORDS_PER_LINE*DATA_WIDTH/8) (4 by default), INDEX_BITS = log2(NUM_LINES), tag = remaining upper bits of off.
- Out of range: pc_in < BASE_ADDR. With rd_en: fetch_err=1, dout_valid=0, no refill. fetch_err is combinational.
- Storage: data[NUM_LINES][LINE_BITS], tag[NUM_LINES], valid[NUM_LINES]; valid bits only are reset.
- FSM states IDLE, REFILL.
- IDLE: hit = rd_en & in-range & valid[idx] & tag match & ~abort -> dout=data[idx], dout_valid=1. rd_en & in-range & miss & ~abort & ~invalidate -> latch idx, tag, mem_addr = pc_in with low OFF_BITS cleared; beat counter=0; next state REFILL.
- REFILL: mem_req=1, dout_valid=0. Each mem_ack cycle writes mem_rdata into fill buffer word[beat], beat++. On the edge of beat WORDS_PER_LINE−1 ack: if not discarded, commit fill buffer to data[idx], tag[idx], valid[idx]=1; next state IDLE.
- Discard flag set by abort or invalidate during REFILL (including the final-ack cycle); burst still completes (mem_req stays high until last ack), line not committed; flag clears on return to IDLE.
- abort in IDLE forces dout_valid=0 that cycle and suppresses miss launch.
- invalidate: all valid bits cleared at next edge; in the same cycle as a commit, invalidate wins (line ends invalid).
- dout=0 whenever dout_valid=0.
- No write port; cache is read-only to the core.

## Timing
- Reset (i_rst=1 at edge): state IDLE, all valid=0, beat=0, discard=0, mem_addr=0. Outputs during/after reset: mem_req=0, dout_valid=0, dout=0, fetch_err follows inputs (0 when rd_en=0).
- Reset mid-refill: mem_req deasserts the cycle after the reset edge; partial line dropped.
- Hit latency: 0 cycles (combinational from pc_in/rd_en).
- Miss with zero-wait memory: miss cycle 0; mem_req 1 in cycles 1..WORDS_PER_LINE; commit on edge ending cycle WORDS_PER_LINE; hit in cycle WORDS_PER_LINE+1 (cycle 5 default) if requester holds pc_in/rd_en.
- mem_ack while mem_req=0 is ignored. Wait states: mem_ack low extends REFILL indefinitely; mem_addr constant throughout.
- pc_in changes during REFILL are ignored; the refill in flight completes for the latched address.

## Test plan
- Cold miss: reset, rd_en=1, pc_in=0x0040_0010, ack every cycle with 0x11111111,0x22222222,0x33333333,0x44444444 -> mem_addr=0x0040_0010, mem_req cycles 1–4, dout_valid=1 cycle 5, dout=0x44444444_33333333_22222222_11111111.
- Conflict: after above, pc_in=0x0040_0410 (same index 1, tag 1) -> miss, mem_addr=0x0040_0410; afterwards 0x0040_0010 misses again; 0x0040_0014 hits same line as 0x0040_0010 while resident.
- Abort: miss on 0x0040_0020, abort pulse on beat 2 -> all 4 beats still acked, mem_req then 0, next fetch of 0x0040_0020 misses again.
- Invalidate: fill lines 0 and 5, pulse invalidate coincident with a final ack -> both lines and the committing line miss afterward.
- Out of range: rd_en=1, pc_in=0x003F_FFFC -> fetch_err=1, dout_valid=0, mem_req stays 0.
- Reset mid-refill: i_rst=1 after beat 1 -> mem_req=0 next cycle, dout_valid=0, prior hits now miss.
